// File: rtl/chrom_eval_pkg.sv
// Shared types and helpers for the chromosome-evaluation responder.
//   state_e  : responder FSM states
//   SLOT_W   : width of one HPS PIO word (input_sequence/expected/valid words)
//   sat_inc  : saturating increment against a caller-supplied ceiling
package chrom_eval_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StHold,
    StNext,
    StDone,
    StRelease
  } state_e;

  localparam int unsigned SLOT_W = 32;

  // Counters narrower than SLOT_W pass their all-ones value as max_val.
  function automatic logic [SLOT_W-1:0] sat_inc(input logic [SLOT_W-1:0] val,
                                                input logic [SLOT_W-1:0] max_val);
    return (val >= max_val) ? val : val + SLOT_W'(1);
  endfunction

endpackage

// File: rtl/chrom_eval_accum.sv
// One saturating error counter.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clr_i   : clear to zero (wins over inc_i)
//   inc_i   : add one, holding at all-ones
//   cnt_o   : current count
// CNT_W must not exceed chrom_eval_pkg::SLOT_W.
module chrom_eval_accum
  import chrom_eval_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = CNT_W'(sat_inc(SLOT_W'(cnt_q), SLOT_W'({CNT_W{1'b1}})));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/chrom_eval_responder.sv
// Fabric-side responder for the HPS chromosome-evaluation handshake. One request loads the
// chromosome, walks every test vector through the evolvable circuit and accumulates masked
// mismatch (and optionally instability) counts into error_sum.
//   clk_clk / reset_reset             : clock, synchronous active-high reset
//   start_processing_chrom_export     : HPS request level
//   done_processing_feedback_export   : HPS acknowledge of done
//   input_sequence                    : word i = stimulus bits for circuit input i
//   expected_output / valid_output    : word k = expected bits / compare mask for output k
//   circuit_out / circuit_in          : evolvable circuit outputs / applied stimulus
//   circuit_cfg_load                  : one-cycle chromosome load strobe
//   ready_to_process_export           : high only while idle
//   done_processing_chrom_export      : results valid, held until acknowledged
//   error_sum                         : slot k mismatches, slot NUM_OUT+k instabilities
// Build option: define STABILITY_CHECK_EN to enable the HOLD window and instability slots.
module chrom_eval_responder
  import chrom_eval_pkg::*;
#(
  parameter int unsigned NUM_IN        = 4,
  parameter int unsigned NUM_OUT       = 4,
  parameter int unsigned NUM_VEC       = 32,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic                         start_processing_chrom_export,
  input  logic                         done_processing_feedback_export,
  input  logic [NUM_IN*SLOT_W-1:0]     input_sequence,
  input  logic [NUM_OUT*SLOT_W-1:0]    expected_output,
  input  logic [NUM_OUT*SLOT_W-1:0]    valid_output,
  input  logic [NUM_OUT-1:0]           circuit_out,
  output logic [NUM_IN-1:0]            circuit_in,
  output logic                         circuit_cfg_load,
  output logic                         ready_to_process_export,
  output logic                         done_processing_chrom_export,
  output logic [2*NUM_OUT*CNT_W-1:0]   error_sum
);

  // One wait counter serves both the settle and hold windows.
  localparam int unsigned MaxWait = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned WaitW   = ($clog2(MaxWait) > 0) ? $clog2(MaxWait) : 1;
  localparam logic [WaitW-1:0] SettleLast = WaitW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]       VecLast    = 5'(NUM_VEC - 1);

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [4:0]         vec_q, vec_d;
  logic [NUM_OUT-1:0] samp_q, samp_d;
  logic [NUM_OUT-1:0] exp_bit, val_bit;
  logic               drive_vec;

`ifdef STABILITY_CHECK_EN
  localparam logic [WaitW-1:0] HoldLast = WaitW'(HOLD_CYCLES - 1);
  logic [NUM_OUT-1:0] unstab_q, unstab_d;
`endif

  // Current vector's expected/valid bits and applied stimulus.
  assign drive_vec = (state_q == StSettle) || (state_q == StHold) || (state_q == StNext);

  always_comb begin
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      exp_bit[k] = expected_output[k*SLOT_W + 32'(vec_q)];
      val_bit[k] = valid_output[k*SLOT_W + 32'(vec_q)];
    end
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      circuit_in[i] = drive_vec ? input_sequence[i*SLOT_W + 32'(vec_q)] : 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    vec_d   = vec_q;
    samp_d  = samp_q;
`ifdef STABILITY_CHECK_EN
    unstab_d = unstab_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_processing_chrom_export) state_d = StLoad;
      end
      StLoad: begin
        vec_d   = '0;
        wait_d  = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (wait_q == SettleLast) begin
          samp_d  = circuit_out;
          wait_d  = '0;
`ifdef STABILITY_CHECK_EN
          state_d = StHold;
`else
          state_d = StNext;
`endif
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
`ifdef STABILITY_CHECK_EN
      StHold: begin
        unstab_d = unstab_q | (circuit_out ^ samp_q);
        if (wait_q == HoldLast) begin
          wait_d  = '0;
          state_d = StNext;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
`endif
      StNext: begin
`ifdef STABILITY_CHECK_EN
        unstab_d = '0;
`endif
        if (vec_q == VecLast) begin
          state_d = StDone;
        end else begin
          vec_d   = vec_q + 5'd1;
          state_d = StSettle;
        end
      end
      StDone: begin
        if (done_processing_feedback_export) state_d = StRelease;
      end
      StRelease: begin
        // Requires start to drop too, so a level left high cannot retrigger.
        if (!start_processing_chrom_export && !done_processing_feedback_export) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      vec_q    <= '0;
      samp_q   <= '0;
`ifdef STABILITY_CHECK_EN
      unstab_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      vec_q    <= vec_d;
      samp_q   <= samp_d;
`ifdef STABILITY_CHECK_EN
      unstab_q <= unstab_d;
`endif
    end
  end

  assign circuit_cfg_load             = (state_q == StLoad);
  assign ready_to_process_export      = (state_q == StIdle);
  assign done_processing_chrom_export = (state_q == StDone);

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_mism
    chrom_eval_accum #(
      .CNT_W(CNT_W)
    ) u_mism (
      .clk_i (clk_clk),
      .rst_i (reset_reset),
      .clr_i (state_q == StLoad),
      .inc_i ((state_q == StNext) && val_bit[k] && (samp_q[k] != exp_bit[k])),
      .cnt_o (error_sum[k*CNT_W +: CNT_W])
    );
  end

`ifdef STABILITY_CHECK_EN
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_inst
    chrom_eval_accum #(
      .CNT_W(CNT_W)
    ) u_inst (
      .clk_i (clk_clk),
      .rst_i (reset_reset),
      .clr_i (state_q == StLoad),
      .inc_i ((state_q == StNext) && val_bit[k] && unstab_q[k]),
      .cnt_o (error_sum[(NUM_OUT+k)*CNT_W +: CNT_W])
    );
  end
`else
  assign error_sum[NUM_OUT*CNT_W +: NUM_OUT*CNT_W] = '0;
`endif

endmodule

// File: tb/tb_chrom_eval_responder.sv
// Self-checking bench for chrom_eval_responder: a LUT-based circuit model with optional
// stuck bits and hold-window glitches, and a per-vector reference count of expected slots.
module tb_chrom_eval_responder;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int NV = 32;
  localparam int S  = 8;
  localparam int H  = 4;
  localparam int CW = 5;
  localparam int MaxCnt = (1 << CW) - 1;
`ifdef STABILITY_CHECK_EN
  localparam bit StabEn = 1'b1;
  localparam int P = S + H + 1;
`else
  localparam bit StabEn = 1'b0;
  localparam int P = S + 1;
`endif

  logic              clk = 1'b0;
  logic              reset, start, feedback;
  logic [NI*32-1:0]  input_sequence;
  logic [NO*32-1:0]  expected_output, valid_output;
  logic [NO-1:0]     circuit_out;
  logic [NI-1:0]     circuit_in;
  logic              cfg_load, ready, done;
  logic [2*NO*CW-1:0] error_sum;

  logic [31:0] seq_w[NI];
  logic [31:0] exp_w[NO];
  logic [31:0] val_w[NO];
  logic [3:0]  lut[16];
  logic [3:0]  s0, s1;
  logic [31:0] gmask;
  int          gout;
  int          tcnt = 1 << 24;
  int          em[2*NO];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  chrom_eval_responder #(
    .NUM_IN(NI), .NUM_OUT(NO), .NUM_VEC(NV),
    .SETTLE_CYCLES(S), .HOLD_CYCLES(H), .CNT_W(CW)
  ) dut (
    .clk_clk                         (clk),
    .reset_reset                     (reset),
    .start_processing_chrom_export   (start),
    .done_processing_feedback_export (feedback),
    .input_sequence                  (input_sequence),
    .expected_output                 (expected_output),
    .valid_output                    (valid_output),
    .circuit_out                     (circuit_out),
    .circuit_in                      (circuit_in),
    .circuit_cfg_load                (cfg_load),
    .ready_to_process_export         (ready),
    .done_processing_chrom_export    (done),
    .error_sum                       (error_sum)
  );

  always_comb begin
    for (int i = 0; i < NI; i++) input_sequence[i*32 +: 32] = seq_w[i];
    for (int k = 0; k < NO; k++) begin
      expected_output[k*32 +: 32] = exp_w[k];
      valid_output[k*32 +: 32]    = val_w[k];
    end
  end

  // Cycle position within the run, counted from the end of the load cycle.
  always @(posedge clk) begin
    if (cfg_load) tcnt <= 0;
    else if (tcnt < (1 << 24)) tcnt <= tcnt + 1;
  end

  // Circuit model: LUT, stuck bits, then a one-cycle flip inside the hold window.
  always_comb begin
    circuit_out = (lut[circuit_in] & ~s0) | s1;
    if (tcnt < NV * P && (tcnt % P) == S + 1 && gmask[tcnt / P]) begin
      circuit_out[gout] = ~circuit_out[gout];
    end
  end

  function automatic logic [CW-1:0] slot(input int s);
    return error_sum[s*CW +: CW];
  endfunction

  function automatic logic [3:0] vec_in(input int v);
    logic [3:0] x;
    for (int i = 0; i < NI; i++) x[i] = seq_w[i][v];
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: count per output over all vectors, then saturate.
  task automatic model();
    logic [3:0] y;
    for (int s = 0; s < 2 * NO; s++) em[s] = 0;
    for (int v = 0; v < NV; v++) begin
      y = (lut[vec_in(v)] & ~s0) | s1;
      for (int k = 0; k < NO; k++) begin
        if (val_w[k][v]) begin
          if (y[k] != exp_w[k][v]) em[k]++;
          if (StabEn && gmask[v] && k == gout) em[NO + k]++;
        end
      end
    end
    for (int s = 0; s < 2 * NO; s++) if (em[s] > MaxCnt) em[s] = MaxCnt;
  endtask

  task automatic perfect_data();
    logic [3:0] y;
    for (int a = 0; a < 16; a++) lut[a] = 4'($urandom);
    for (int i = 0; i < NI; i++) seq_w[i] = $urandom;
    s0 = '0; s1 = '0; gmask = '0; gout = 0;
    for (int k = 0; k < NO; k++) val_w[k] = '1;
    for (int v = 0; v < NV; v++) begin
      y = lut[vec_in(v)];
      for (int k = 0; k < NO; k++) exp_w[k][v] = y[k];
    end
  endtask

  task automatic run_and_check(input string name, input bit drop_start);
    int lat, cfg_seen, ready_seen;
    model();
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    check({name, "_cfg_first"}, 32'(cfg_load), 1);
    lat = 0; cfg_seen = 0; ready_seen = 0;
    while (!done && lat < 4000) begin
      @(negedge clk);
      lat++;
      if (drop_start && lat == 5) start = 1'b0;
      cfg_seen += int'(cfg_load);
      ready_seen += int'(ready);
    end
    check({name, "_latency"}, 32'(lat), 32'(1 + NV * P));
    check({name, "_cfg_extra"}, 32'(cfg_seen), 0);
    check({name, "_ready_run"}, 32'(ready_seen), 0);
    for (int s = 0; s < 2 * NO; s++) begin
      check($sformatf("%s_slot%0d", name, s), 32'(slot(s)), 32'(em[s]));
    end
    feedback = 1'b1;
    @(negedge clk);
    check({name, "_done_fall"}, 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    check({name, "_rel_ready"}, 32'(ready), 0);
    check({name, "_hold_slot0"}, 32'(slot(0)), 32'(em[0]));
    feedback = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({name, "_no_retrig"}, 32'(ready), 32'(!start));
    check({name, "_no_cfg"}, 32'(cfg_load), 0);
    start = 1'b0;
    @(negedge clk);
    check({name, "_idle"}, 32'(ready), 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; feedback = 1'b0;
    perfect_data();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_cfg", 32'(cfg_load), 0);
    check("rst_cin", 32'(circuit_in), 0);
    for (int s = 0; s < 2 * NO; s++) check($sformatf("rst_slot%0d", s), 32'(slot(s)), 0);

    // Perfect circuit, start held through done.
    perfect_data();
    run_and_check("perfect", 1'b0);

    // Output 0 stuck low against 0xFFFF0000; start dropped mid-run.
    perfect_data();
    s0 = 4'b0001;
    exp_w[0] = 32'hFFFF_0000;
    run_and_check("stuck", 1'b1);
    check("stuck_slot0_16", 32'(slot(0)), 16);

    // Same fault fully masked.
    val_w[0] = 32'h0000_FFFF;
    run_and_check("masked", 1'b0);

    // Output 2 glitches in the hold window of vectors 3 and 7.
    perfect_data();
    gmask = 32'h0000_0088;
    gout  = 2;
    run_and_check("glitch", 1'b0);
    check("glitch_slot6", 32'(slot(6)), StabEn ? 2 : 0);

    // Every compare wrong: 32 mismatches saturate the 5-bit counters.
    perfect_data();
    for (int k = 0; k < NO; k++) exp_w[k] = ~exp_w[k];
    run_and_check("sat", 1'b0);
    check("sat_slot3", 32'(slot(3)), MaxCnt);

    // Random circuits, expectations, masks, faults and glitches.
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 16; a++) lut[a] = 4'($urandom);
      for (int i = 0; i < NI; i++) seq_w[i] = $urandom;
      for (int k = 0; k < NO; k++) begin
        exp_w[k] = $urandom;
        val_w[k] = $urandom;
      end
      s0 = 4'($urandom) & 4'($urandom);
      s1 = 4'($urandom) & 4'($urandom) & ~s0;
      gmask = $urandom;
      gout  = int'($urandom_range(NO - 1, 0));
      run_and_check($sformatf("rand%0d", r), r[0]);
    end

    // Reset in the middle of vector 3 after three mismatching vectors.
    perfect_data();
    for (int k = 0; k < NO; k++) exp_w[k] = ~exp_w[k];
    @(negedge clk) start = 1'b1;
    repeat (1 + 3 * P + S + 1) @(negedge clk);
    check("mid_slot0", 32'(slot(0)), 3);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 32'(ready), 1);
    check("abort_done", 32'(done), 0);
    check("abort_cin", 32'(circuit_in), 0);
    check("abort_slot0", 32'(slot(0)), 0);
    @(negedge clk);
    check("abort_stay", 32'(ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
